ddr2_wr_arb: RTL and testbench
==============================

// Module: ddr2_wr_arb
// PURPOSE
//  Round-robin arbiter that shares the single DDR2 controller write port (aw/w/b) between
//  NUM_M write masters. Grants one whole burst at a time (address, all data beats, response),
//  then rotates priority. Sits between the user masters and the controller write port.
//  All ports are synchronous to clk800m.
// PARAMETERS
//  NUM_M   2   number of masters, 2..4
//  ADDR_W  26  burst address width (BA+ROW+COL)
//  DATA_W  16  write data width (2*DQ)
//  GW      1   grant index width, clog2(NUM_M)
// PORTS
//  clk800m     in   1              clock
//  rstn_async  in   1              reset, asynchronous, active-low
//  m_awvalid   in   NUM_M          per-master burst request
//  m_awready   out  NUM_M          per-master address accept
//  m_awaddr    in   NUM_M*ADDR_W   packed addresses, master i at [i*ADDR_W +: ADDR_W]
//  m_awlen     in   NUM_M*8        packed burst lengths (beats-1)
//  m_wvalid    in   NUM_M          per-master data valid
//  m_wready    out  NUM_M          per-master data accept
//  m_wlast     in   NUM_M          per-master last beat
//  m_wdata     in   NUM_M*DATA_W   packed write data
//  m_bvalid    out  NUM_M          per-master write response
//  m_bready    in   NUM_M          per-master response accept
//  s_awvalid   out  1              to controller
//  s_awready   in   1              from controller
//  s_awaddr    out  ADDR_W         to controller
//  s_awlen     out  8              to controller
//  s_wvalid    out  1              to controller
//  s_wready    in   1              from controller
//  s_wlast     out  1              to controller
//  s_wdata     out  DATA_W         to controller
//  s_bvalid    in   1              from controller
//  s_bready    out  1              to controller
//  gnt_idx     out  GW             current/last grant index
//  busy        out  1              state != IDLE
//  err_len     out  1              sticky: wlast disagrees with awlen beat count
// BEHAVIOUR
//  - Reset: async assert; deassert through 2-flop synchronizer. State=IDLE, rr_ptr=0,
//    gnt_idx=0, err_len=0, beat_cnt=0. All valid/ready outputs 0; s_* data outputs 0.
//  - FSM IDLE->AW->W->B->IDLE, one burst per grant.
//  - IDLE: if any m_awvalid, register winner = first requester searching rr_ptr,
//    rr_ptr+1, ... mod NUM_M into gnt_idx. Next state AW; 1-cycle grant latency.
//    No requests: stay IDLE.
//  - AW: s_awvalid=1; s_awaddr/s_awlen = granted master's fields; m_awready[gnt]=s_awready,
//    others 0. On s_awvalid&&s_awready: latch len=s_awlen, beat_cnt=0, go W.
//  - W: s_wvalid/s_wlast/s_wdata = granted master's; m_wready[gnt]=s_wready, others 0.
//    Each s_wvalid&&s_wready: beat_cnt++. On handshake with wlast=1, go B.
//    err_len sets if wlast=1 while beat_cnt!=len, or wlast=0 while beat_cnt==len. On the
//    second case still go B after beat len; no further beats forwarded.
//  - B: m_bvalid[gnt]=s_bvalid, s_bready=m_bready[gnt]. On s_bvalid&&s_bready:
//    rr_ptr=(gnt_idx+1) mod NUM_M, go IDLE.
//  - Non-granted masters always see ready=0 and bvalid=0; their requests are held, never dropped.
//  - Simultaneous requests: rotating priority; no master waits more than NUM_M-1 bursts.
//  - A request dropped in IDLE before it is granted is ignored. After grant, AW holds
//    until accepted: masters must keep awvalid asserted.
//  - beat_cnt is 9 bits: awlen=255 gives 256 beats with no wrap.
//  - Reset mid-burst: FSM aborts to IDLE. Controller-side recovery is outside this block.
// TESTING
//  1 Single master 0, awlen=3, data 0x1111..0x4444 -> s_awaddr matches, 4 beats forwarded
//    in order, m_bvalid[0] pulses once, rr_ptr=1.
//  2 Masters 0 and 1 request in the same cycle from reset -> grant order 0,1,0,1 over 4
//    back-to-back bursts; gnt_idx follows it.
//  3 s_wready toggled every other cycle -> no beat lost or duplicated; s_wdata stable while
//    s_wvalid&&!s_wready.
//  4 awlen=1 but wlast on beat 0 -> err_len=1, FSM goes B. awlen=255 -> 256 beats, err_len=0.
//  5 Master 1 asserts wvalid while master 0 is granted -> m_wready[1]=0, no s_w* leak.
//  6 rstn_async pulsed low in W -> outputs go 0 immediately; busy=0 two cycles after release.

Source files
------------

// File: rtl/ddr2_wr_arb_if.sv
// Write-channel bundle (aw/w/b) for N ports sharing one DDR2 write path.
// Master side drives requests and data; slave side answers with ready/response.
interface ddr2_wr_arb_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
);
  logic [N-1:0]        awvalid;
  logic [N-1:0]        awready;
  logic [N*ADDR_W-1:0] awaddr;
  logic [N*8-1:0]      awlen;
  logic [N-1:0]        wvalid;
  logic [N-1:0]        wready;
  logic [N-1:0]        wlast;
  logic [N*DATA_W-1:0] wdata;
  logic [N-1:0]        bvalid;
  logic [N-1:0]        bready;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wlast, wdata,
    output bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wlast, wdata,
    input  bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/ddr2_wr_arb.sv
// Round-robin arbiter sharing one DDR2 write port between NUM_M masters,
// granting a whole burst (aw, all w beats, b) before rotating priority.
module ddr2_wr_arb #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16,
  parameter int GW     = 1
) (
  input  logic          clk800m,
  input  logic          rstn_async,
  ddr2_wr_arb_if.slave  m,
  ddr2_wr_arb_if.master s,
  output logic [GW-1:0] gnt_idx,
  output logic          busy,
  output logic          err_len
);

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] nxt_ptr;
  logic          found;
  logic [7:0]    len_q;
  logic [7:0]    aw_len;
  logic [8:0]    beat_cnt;
  logic          at_len;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;

  // Assert immediately, release two clocks later.
  always_ff @(posedge clk800m or negedge rstn_async) begin
    if (!rstn_async) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    int k;
    found = 1'b0;
    win   = rr_ptr;
    for (int i = 0; i < NUM_M; i++) begin
      k = (int'(rr_ptr) + i) % NUM_M;
      if (!found && m.awvalid[k]) begin
        found = 1'b1;
        win   = GW'(k);
      end
    end
  end

  assign nxt_ptr = (gnt_idx == GW'(NUM_M - 1)) ?
                   '0 : gnt_idx + 1'b1;
  assign aw_len  = m.awlen[gnt_idx*8 +: 8];
  assign at_len  = (beat_cnt == {1'b0, len_q});
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    m.awready = '0;
    m.wready  = '0;
    m.bvalid  = '0;
    s.awvalid = '0;
    s.awaddr  = '0;
    s.awlen   = '0;
    s.wvalid  = '0;
    s.wlast   = '0;
    s.wdata   = '0;
    s.bready  = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) state_d = AW;
      end
      AW: begin
        s.awvalid          = 1'b1;
        s.awaddr           = m.awaddr[gnt_idx*ADDR_W +: ADDR_W];
        s.awlen            = aw_len;
        m.awready[gnt_idx] = s.awready[0];
        aw_hs              = s.awready[0];
        if (aw_hs) state_d = W;
      end
      W: begin
        s.wvalid          = m.wvalid[gnt_idx];
        s.wlast           = m.wlast[gnt_idx];
        s.wdata           = m.wdata[gnt_idx*DATA_W +: DATA_W];
        m.wready[gnt_idx] = s.wready[0];
        w_hs              = m.wvalid[gnt_idx] && s.wready[0];
        // A missing wlast still closes the burst at the announced length.
        if (w_hs && (m.wlast[gnt_idx] || at_len)) state_d = B;
      end
      B: begin
        m.bvalid[gnt_idx] = s.bvalid[0];
        s.bready          = m.bready[gnt_idx];
        b_hs              = s.bvalid[0] && m.bready[gnt_idx];
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk800m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) gnt_idx <= win;
      if (aw_hs) begin
        len_q    <= aw_len;
        beat_cnt <= '0;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (m.wlast[gnt_idx] != at_len) err_len <= 1'b1;
      end
      if (b_hs) rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_ddr2_wr_arb.sv
// Directed bench for ddr2_wr_arb: two masters, one controller port,
// expected values computed from the burst parameters of each step.
module tb_ddr2_wr_arb;

  logic       clk800m    = 1'b0;
  logic       rstn_async = 1'b0;
  logic [0:0] gnt_idx;
  logic       busy;
  logic       err_len;
  int         n_chk  = 0;
  int         n_fail = 0;

  ddr2_wr_arb_if #(.N(2), .ADDR_W(26), .DATA_W(16)) mi ();
  ddr2_wr_arb_if #(.N(1), .ADDR_W(26), .DATA_W(16)) si ();

  ddr2_wr_arb #(
    .NUM_M (2),
    .ADDR_W(26),
    .DATA_W(16),
    .GW    (1)
  ) dut (
    .clk800m   (clk800m),
    .rstn_async(rstn_async),
    .m         (mi),
    .s         (si),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .err_len   (err_len)
  );

  always #5 clk800m = ~clk800m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int g, input int b);
    return 16'((b + 1) * 'h1111) ^ 16'(g * 'h8000);
  endfunction

  task automatic clr_inputs();
    mi.awvalid = '0;
    mi.awaddr  = '0;
    mi.awlen   = '0;
    mi.wvalid  = '0;
    mi.wlast   = '0;
    mi.wdata   = '0;
    mi.bready  = '0;
    si.awready = '0;
    si.wready  = '0;
    si.bvalid  = '0;
  endtask

  task automatic do_reset();
    rstn_async = 1'b0;
    clr_inputs();
    @(negedge clk800m);
    rstn_async = 1'b1;
    repeat (3) @(negedge clk800m);
  endtask

  task automatic req(input int g, input logic [25:0] a,
                     input logic [7:0] l);
    mi.awvalid[g]        = 1'b1;
    mi.awaddr[g*26 +: 26] = a;
    mi.awlen[g*8 +: 8]    = l;
  endtask

  // Runs one granted burst; lastb is the beat carrying wlast.
  task automatic do_burst(input int g, input logic [25:0] a,
                          input int len, input int lastb,
                          input bit tog);
    int nb;
    nb = ((lastb < len) ? lastb : len) + 1;
    @(negedge clk800m); #1;
    chk("gnt_idx", gnt_idx, g);
    chk("busy_aw", busy, 1);
    chk("s_awvalid", si.awvalid, 1);
    chk("s_awaddr", si.awaddr, a);
    chk("s_awlen", si.awlen, len);
    chk("m_awready_wait", mi.awready, 0);
    si.awready = 1'b1;
    #1 chk("m_awready", mi.awready, 1 << g);
    @(negedge clk800m);
    si.awready    = 1'b0;
    mi.awvalid[g] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      mi.wvalid[g]         = 1'b1;
      mi.wdata[g*16 +: 16] = pat(g, b);
      mi.wlast[g]          = (b == lastb);
      if (tog) begin
        si.wready = 1'b0;
        #1;
        chk("s_wdata_stall", si.wdata, pat(g, b));
        chk("m_wready_stall", mi.wready, 0);
        @(negedge clk800m);
      end
      si.wready = 1'b1;
      #1;
      chk("s_wdata", si.wdata, pat(g, b));
      chk("s_wlast", si.wlast, b == lastb);
      chk("m_wready", mi.wready, 1 << g);
      @(negedge clk800m);
    end
    mi.wlast[g] = 1'b0;
    #1;
    chk("s_wvalid_in_b", si.wvalid, 0);
    chk("m_wready_in_b", mi.wready, 0);
    mi.wvalid[g] = 1'b0;
    si.wready    = 1'b0;
    chk("m_bvalid_wait", mi.bvalid, 0);
    si.bvalid    = 1'b1;
    mi.bready[g] = 1'b1;
    #1;
    chk("m_bvalid", mi.bvalid, 1 << g);
    chk("s_bready", si.bready, 1);
    @(negedge clk800m);
    si.bvalid    = 1'b0;
    mi.bready[g] = 1'b0;
    #1 chk("busy_idle", busy, 0);
  endtask

  initial begin
    clr_inputs();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_idx, 0);
    chk("rst_err", err_len, 0);
    chk("rst_s_awvalid", si.awvalid, 0);
    chk("rst_s_awaddr", si.awaddr, 0);
    chk("rst_s_wvalid", si.wvalid, 0);
    chk("rst_s_wdata", si.wdata, 0);
    chk("rst_m_awready", mi.awready, 0);
    chk("rst_m_bvalid", mi.bvalid, 0);
    do_reset();

    // Single master 0 with master 1 pushing stray data.
    req(0, 26'h0ABCDEF, 8'd3);
    mi.wvalid[1]      = 1'b1;
    mi.wdata[16 +: 16] = 16'hDEAD;
    mi.wlast[1]       = 1'b1;
    do_burst(0, 26'h0ABCDEF, 3, 3, 1'b0);
    mi.wvalid[1] = 1'b0;
    mi.wlast[1]  = 1'b0;
    // Pointer moved to 1: a tie now goes to master 1.
    req(0, 26'h0000100, 8'd0);
    req(1, 26'h3000200, 8'd1);
    do_burst(1, 26'h3000200, 1, 1, 1'b0);
    do_burst(0, 26'h0000100, 0, 0, 1'b0);

    do_reset();
    req(0, 26'h0111111, 8'd1);
    req(1, 26'h2222222, 8'd2);
    do_burst(0, 26'h0111111, 1, 1, 1'b0);
    mi.awvalid[0] = 1'b1;
    do_burst(1, 26'h2222222, 2, 2, 1'b0);
    mi.awvalid[1] = 1'b1;
    do_burst(0, 26'h0111111, 1, 1, 1'b0);
    do_burst(1, 26'h2222222, 2, 2, 1'b0);

    req(0, 26'h1234567, 8'd3);
    do_burst(0, 26'h1234567, 3, 3, 1'b1);
    chk("err_after_ok", err_len, 0);

    // Early wlast.
    req(1, 26'h0000042, 8'd1);
    do_burst(1, 26'h0000042, 1, 0, 1'b0);
    chk("err_early_last", err_len, 1);

    // Reset in the middle of W.
    req(0, 26'h0000777, 8'd7);
    @(negedge clk800m); #1;
    chk("mid_busy", busy, 1);
    si.awready = 1'b1;
    @(negedge clk800m);
    si.awready    = 1'b0;
    mi.awvalid[0] = 1'b0;
    mi.wvalid[0]  = 1'b1;
    mi.wdata[15:0] = 16'hBEEF;
    #1;
    chk("mid_s_wvalid", si.wvalid, 1);
    chk("mid_s_wdata", si.wdata, 16'hBEEF);
    rstn_async = 1'b0;
    #1;
    chk("arst_s_wvalid", si.wvalid, 0);
    chk("arst_s_wdata", si.wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_len, 0);
    clr_inputs();
    @(negedge clk800m);
    rstn_async = 1'b1;
    @(negedge clk800m); #1 chk("rel_busy_1", busy, 0);
    @(negedge clk800m); #1 chk("rel_busy_2", busy, 0);
    @(negedge clk800m);

    req(0, 26'h3FFFFFF, 8'd255);
    do_burst(0, 26'h3FFFFFF, 255, 255, 1'b0);
    chk("err_256", err_len, 0);

    // Missing wlast: burst closes after beat len.
    req(1, 26'h0000055, 8'd2);
    do_burst(1, 26'h0000055, 2, 5, 1'b0);
    chk("err_missing_last", err_len, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
